video_timing_ctrl: RTL and testbench
====================================

VIDEO_TIMING_CTRL -- requirements
Module: video_timing_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line SHALL be:
  H_ACTIVE, 640, visible pixels per line
  H_FP, 16, horizontal front porch (pixels)
  H_SYNC, 96, horizontal sync width (pixels)
  H_BP, 48, horizontal back porch (pixels)
  V_ACTIVE, 480, visible lines per frame
  V_FP, 10, vertical front porch (lines)
  V_SYNC, 2, vertical sync width (lines)
  V_BP, 33, vertical back porch (lines)
  SYNC_POL, 0, sync active level (0 = active-low)
REQ-002 Ports (name, direction, width, meaning) SHALL be:
  i_clk  in  1  pixel clock; single clock domain
  i_rst_n  in  1  asynchronous, active-low reset
  i_en  in  1  run request; frames start/stop only on frame boundaries
  o_ve  out  1  video enable to all TMDS channel encoders
  o_hs  out  1  horizontal sync at SYNC_POL level
  o_vs  out  1  vertical sync at SYNC_POL level
  o_ctl  out  2  blue-channel control {o_vs,o_hs}; red/green get 2'b00
  o_x  out  12  pixel column, valid when o_ve=1
  o_y  out  12  line number, valid when o_ve=1
  o_line_start  out  1  one-cycle pulse at h=0
  o_frame_start  out  1  one-cycle pulse at h=0,v=0
  o_busy  out  1  state != IDLE

Function
REQ-003 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525). The design SHALL reject, at elaboration, any total > 4096 or any zero-width field.
REQ-004 h counter SHALL run 0..H_TOTAL-1 and wrap to 0; v SHALL increment on h wrap and wrap 0 after V_TOTAL-1.
REQ-005 Line order SHALL be active, front porch, sync, back porch: hs active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. [656,752) by default; vs active for v in [490,492), the whole line wide.
REQ-006 o_ve SHALL be 1 iff state != IDLE and h < H_ACTIVE and v < V_ACTIVE; o_x=h and o_y=v while o_ve=1, otherwise 0.
REQ-007 All outputs SHALL be registered and mutually aligned: each reflects the same (h,v) pair in the same cycle.
REQ-008 The FSM SHALL have the states IDLE, RUN and DRAIN.
REQ-009 IDLE: h=v=0 held; o_ve=0; hs/vs at inactive level (~SYNC_POL); all pulses 0. i_en=1 -> RUN; the first RUN cycle presents h=0,v=0 with o_frame_start=1.
REQ-010 RUN: i_en=0 -> DRAIN, except at the last pixel of a frame (h=H_TOTAL-1, v=V_TOTAL-1), where it -> IDLE directly.
REQ-011 DRAIN SHALL keep counting normally. At the last pixel of the frame it -> IDLE. If i_en=1 at any DRAIN cycle, it -> RUN with no counter disturbance.
REQ-012 Frames SHALL never be truncated: every frame started completes all V_TOTAL lines.
REQ-013 o_line_start SHALL pulse on every h=0 cycle while not IDLE; o_frame_start SHALL pulse only when additionally v=0.
REQ-014 i_en SHALL be sampled every cycle; it has no handshake and there is no backpressure.

Reset
REQ-015 Asserting i_rst_n=0 SHALL immediately (asynchronously) force state IDLE and h=v=0. Outputs SHALL go to: o_ve=0, o_hs=o_vs=~SYNC_POL, o_ctl={~SYNC_POL,~SYNC_POL}, o_x=o_y=0, pulses 0, o_busy=0.
REQ-016 Reset mid-frame SHALL abandon the frame. After deassertion the block SHALL wait in IDLE for i_en.

Structure
REQ-017 A shared package video_pkg SHALL hold:
  state enum {IDLE, RUN, DRAIN}
  default 640x480@60 timing constants
  TMDS control token constants (2'b00..2'b11 tokens), reused by the encoders
REQ-018 One sub-module, timing_axis, SHALL be instantiated twice (horizontal, vertical). It is a counter with an advance enable, a wrap output and an in-sync/in-active decode, parameterised by the four field widths.

Verification
REQ-019 Reset, then i_en=1 held: first frame_start one cycle after i_en is sampled. Across 2 frames: 800 cycles between line_starts, 420000 between frame_starts, 307200 o_ve cycles per frame.
REQ-020 Sync placement (defaults): o_hs=0 exactly at h=656..751; o_vs=0 for all of lines 490..491; o_ctl={o_vs,o_hs} every cycle.
REQ-021 Drop i_en mid-frame (v=100): the frame completes to h=799,v=524, then o_busy=0, o_ve=0, syncs inactive, and no further frame_start.
REQ-022 Drop i_en at v=200 and re-raise it at v=300: no gap, frame_start period stays 420000, state returns to RUN.
REQ-023 Pulse i_rst_n low for 3 cycles at h=400,v=250: outputs reach reset values without a clock edge; after release, with i_en=1, a fresh frame_start occurs at h=0,v=0.
REQ-024 Small parameters (H 4/1/2/1, V 3/1/1/1, SYNC_POL=1): exact cycle-by-cycle match of all outputs against a reference model, including the drop of i_en exactly at the last pixel (RUN->IDLE directly).

Source files
------------

// File: rtl/video_pkg.sv
// Shared definitions for the video timing controller and the TMDS encoders it feeds.
package video_pkg;

    localparam int CNT_W     = 12;
    localparam int MAX_TOTAL = 4096;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } vtc_state_e;

    // 640x480@60 with a 25.175 MHz pixel clock
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam logic [9:0] TMDS_CTL_00 = 10'b1101010100;
    localparam logic [9:0] TMDS_CTL_01 = 10'b0010101011;
    localparam logic [9:0] TMDS_CTL_10 = 10'b0101010100;
    localparam logic [9:0] TMDS_CTL_11 = 10'b1010101011;

    function automatic logic [9:0] tmds_ctl_token(input logic [1:0] ctl);
        logic [9:0] tok;
        case (ctl)
            2'b00:   tok = TMDS_CTL_00;
            2'b01:   tok = TMDS_CTL_01;
            2'b10:   tok = TMDS_CTL_10;
            2'b11:   tok = TMDS_CTL_11;
            default: tok = TMDS_CTL_00;
        endcase
        return tok;
    endfunction

    function automatic bit axis_cfg_ok(input int active, input int fp, input int sync, input int bp);
        return (active > 0) && (fp > 0) && (sync > 0) && (bp > 0) &&
               (active + fp + sync + bp <= MAX_TOTAL);
    endfunction

endpackage

// File: rtl/timing_axis.sv
// One raster axis: wrapping position counter plus active/sync decode of the position it moves to next.
module timing_axis
    import video_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_adv,
    output logic             o_wrap,
    output logic [CNT_W-1:0] o_cnt_nxt,
    output logic             o_active_nxt,
    output logic             o_sync_nxt
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACT_END  = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_BEG = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(ACTIVE + FP + SYNC);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next position: hold, step, or wrap at the last position
    always_comb begin
        if (!i_adv) begin
            cnt_d = cnt_q;
        end else if (cnt_q == LAST) begin
            cnt_d = 12'd0;
        end else begin
            cnt_d = cnt_q + 12'd1;
        end
    end

    // Position register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= 12'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_wrap       = i_adv && (cnt_q == LAST);
    assign o_cnt_nxt    = cnt_d;
    assign o_active_nxt = (cnt_d < ACT_END);
    assign o_sync_nxt   = (cnt_d >= SYNC_BEG) && (cnt_d < SYNC_END);

endmodule

// File: rtl/video_timing_ctrl.sv
// Raster timing generator for a TMDS transmitter; frames start and stop only on frame boundaries.
// Outputs are registered from the next-cycle position so all of them describe the same (h,v).
module video_timing_ctrl
    import video_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    output logic             o_ve,
    output logic             o_hs,
    output logic             o_vs,
    output logic [1:0]       o_ctl,
    output logic [CNT_W-1:0] o_x,
    output logic [CNT_W-1:0] o_y,
    output logic             o_line_start,
    output logic             o_frame_start,
    output logic             o_busy
);

    if (!axis_cfg_ok(H_ACTIVE, H_FP, H_SYNC, H_BP) ||
        !axis_cfg_ok(V_ACTIVE, V_FP, V_SYNC, V_BP)) begin : g_bad_cfg
        $error("video_timing_ctrl: zero-width timing field or total above 4096");
    end

    vtc_state_e       state_q, state_d;
    logic             h_adv_s, h_wrap_s, v_wrap_s;
    logic [CNT_W-1:0] h_nxt_s, v_nxt_s;
    logic             h_act_nxt_s, h_sync_nxt_s, v_act_nxt_s, v_sync_nxt_s;

    logic             ve_q, ve_d, hs_q, hs_d, vs_q, vs_d;
    logic [1:0]       ctl_q, ctl_d;
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    logic             line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic             busy_q, busy_d;

    assign h_adv_s = (state_q != IDLE);

    timing_axis #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
    ) u_h_axis (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_adv        (h_adv_s),
        .o_wrap       (h_wrap_s),
        .o_cnt_nxt    (h_nxt_s),
        .o_active_nxt (h_act_nxt_s),
        .o_sync_nxt   (h_sync_nxt_s)
    );

    timing_axis #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
    ) u_v_axis (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_adv        (h_wrap_s),
        .o_wrap       (v_wrap_s),
        .o_cnt_nxt    (v_nxt_s),
        .o_active_nxt (v_act_nxt_s),
        .o_sync_nxt   (v_sync_nxt_s)
    );

    // Next state; v_wrap_s marks the last pixel of a running frame
    always_comb begin
        case (state_q)
            IDLE: begin
                if (i_en) state_d = RUN;
                else      state_d = IDLE;
            end
            RUN, DRAIN: begin
                if (i_en)          state_d = RUN;
                else if (v_wrap_s) state_d = IDLE;
                else               state_d = DRAIN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output values for the position presented next cycle
    always_comb begin
        busy_d = (state_d != IDLE);
        ve_d   = busy_d && h_act_nxt_s && v_act_nxt_s;
        if (busy_d && h_sync_nxt_s) hs_d = SYNC_POL;
        else                        hs_d = ~SYNC_POL;
        if (busy_d && v_sync_nxt_s) vs_d = SYNC_POL;
        else                        vs_d = ~SYNC_POL;
        ctl_d = {vs_d, hs_d};
        if (ve_d) begin
            x_d = h_nxt_s;
            y_d = v_nxt_s;
        end else begin
            x_d = 12'd0;
            y_d = 12'd0;
        end
        line_start_d  = busy_d && (h_nxt_s == 12'd0);
        frame_start_d = line_start_d && (v_nxt_s == 12'd0);
    end

    // State and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= IDLE;
            ve_q          <= 1'b0;
            hs_q          <= ~SYNC_POL;
            vs_q          <= ~SYNC_POL;
            ctl_q         <= {~SYNC_POL, ~SYNC_POL};
            x_q           <= 12'd0;
            y_q           <= 12'd0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ve_q          <= ve_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            ctl_q         <= ctl_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
        end
    end

    assign o_ve          = ve_q;
    assign o_hs          = hs_q;
    assign o_vs          = vs_q;
    assign o_ctl         = ctl_q;
    assign o_x           = x_q;
    assign o_y           = y_q;
    assign o_line_start  = line_start_q;
    assign o_frame_start = frame_start_q;
    assign o_busy        = busy_q;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Directed bench for video_timing_ctrl on a tiny raster (H 4/1/2/1, V 3/1/1/1, active-high syncs).
module tb_video_timing_ctrl;

    localparam int HT = 8;
    localparam int VT = 6;
    localparam int FT = HT * VT;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        ve, hs, vs, ls, fs, busy;
    logic [1:0]  ctl;
    logic [11:0] x, y;
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    video_timing_ctrl #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b1)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .o_ve         (ve),
        .o_hs         (hs),
        .o_vs         (vs),
        .o_ctl        (ctl),
        .o_x          (x),
        .o_y          (y),
        .o_line_start (ls),
        .o_frame_start(fs),
        .o_busy       (busy)
    );

    wire [31:0] dut_vec = {ve, hs, vs, ctl, x, y, ls, fs, busy};

    // Reference position/state: 0 idle, 1 run, 2 drain
    int m_st = 0;
    int m_h  = 0;
    int m_v  = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st <= 0; m_h <= 0; m_v <= 0;
        end else if (m_st == 0) begin
            if (en) m_st <= 1;
        end else begin
            m_h <= (m_h == HT-1) ? 0 : m_h + 1;
            if (m_h == HT-1) m_v <= (m_v == VT-1) ? 0 : m_v + 1;
            m_st <= en ? 1 : ((m_h == HT-1 && m_v == VT-1) ? 0 : 2);
        end
    end

    function automatic logic [31:0] model_vec();
        logic b, e_ve, e_hs, e_vs, e_ls;
        b    = (m_st != 0);
        e_ve = b && (m_h < 4) && (m_v < 3);
        e_hs = b && (m_h >= 5) && (m_h < 7);
        e_vs = b && (m_v == 4);
        e_ls = b && (m_h == 0);
        return {e_ve, e_hs, e_vs, e_vs, e_hs, e_ve ? 12'(m_h) : 12'd0, e_ve ? 12'(m_v) : 12'd0,
                e_ls, e_ls && (m_v == 0), b};
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++; if (dut_vec !== 32'h0) $display("FAIL reset_outputs: got %h want %h", dut_vec, 32'h0); else n_pass++;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if ({busy, ls, fs} !== 3'b000) $display("FAIL idle_no_en: got %b want 000", {busy, ls, fs}); else n_pass++;
    endtask

    task automatic test_start();
        en = 1'b1;
        @(negedge clk);
        n_checks++; if (dut_vec !== 32'h8000_0007) $display("FAIL first_frame_start: got %h want %h", dut_vec, 32'h8000_0007); else n_pass++;
        @(negedge clk);
        n_checks++; if (dut_vec !== 32'h8000_8001) $display("FAIL second_pixel: got %h want %h", dut_vec, 32'h8000_8001); else n_pass++;
    endtask

    task automatic test_periods();
        int last_ls, last_fs, ve_cnt;
        for (int i = 0; i < 100 && fs !== 1'b1; i++) @(negedge clk);
        n_checks++; if (fs !== 1'b1) $display("FAIL periods_fs_seen: got %b want 1", fs); else n_pass++;
        last_ls = 0; last_fs = 0; ve_cnt = int'(ve);
        for (int k = 1; k <= 2*FT; k++) begin
            @(negedge clk);
            if (k < FT) ve_cnt += int'(ve);
            if (ls === 1'b1) begin
                n_checks++; if (k - last_ls != HT) $display("FAIL line_period: got %0d want %0d", k - last_ls, HT); else n_pass++;
                last_ls = k;
            end
            if (fs === 1'b1) begin
                n_checks++; if (k - last_fs != FT) $display("FAIL frame_period: got %0d want %0d", k - last_fs, FT); else n_pass++;
                last_fs = k;
            end
        end
        n_checks++; if (ve_cnt != 12) $display("FAIL ve_per_frame: got %0d want 12", ve_cnt); else n_pass++;
        n_checks++; if (last_fs != 2*FT) $display("FAIL last_frame_start: got %0d want %0d", last_fs, 2*FT); else n_pass++;
    endtask

    task automatic test_sync();
        int h, v;
        logic e_hs, e_vs, e_ve;
        for (int p = 0; p < FT; p++) begin
            h = p % HT; v = p / HT;
            e_hs = (h >= 5) && (h <= 6);
            e_vs = (v == 4);
            e_ve = (h < 4) && (v < 3);
            n_checks++;
            if ({hs, vs, ctl, ve, x, y} !== {e_hs, e_vs, e_vs, e_hs, e_ve, e_ve ? 12'(h) : 12'd0, e_ve ? 12'(v) : 12'd0})
                $display("FAIL sync_place h=%0d v=%0d: got hs%b vs%b ctl%b ve%b x%0d y%0d", h, v, hs, vs, ctl, ve, x, y);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_drain();
        int first_idle, fs_cnt;
        repeat (2*HT) @(negedge clk);
        n_checks++; if ({ls, y} !== {1'b1, 12'd2}) $display("FAIL drain_at_line2: got ls%b y%0d want ls1 y2", ls, y); else n_pass++;
        en = 1'b0;
        first_idle = 0; fs_cnt = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (busy === 1'b0 && first_idle == 0) first_idle = n;
            if (fs === 1'b1) fs_cnt++;
        end
        n_checks++; if (first_idle != 32) $display("FAIL drain_length: got %0d want 32", first_idle); else n_pass++;
        n_checks++; if (fs_cnt != 0) $display("FAIL drain_no_fs: got %0d want 0", fs_cnt); else n_pass++;
        n_checks++; if ({ve, hs, vs, ctl} !== 5'b0) $display("FAIL drain_idle_outs: got %b want 00000", {ve, hs, vs, ctl}); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int k, gap;
        en = 1'b1;
        @(negedge clk);
        n_checks++; if (fs !== 1'b1) $display("FAIL reraise_start: got %b want 1", fs); else n_pass++;
        repeat (HT) @(negedge clk);
        en = 1'b0;
        k = HT; gap = 0;
        repeat (2*HT) begin @(negedge clk); k++; if (busy !== 1'b1) gap++; end
        en = 1'b1;
        while (k < 100) begin
            @(negedge clk); k++;
            if (busy !== 1'b1) gap++;
            if (fs === 1'b1) break;
        end
        n_checks++; if (k != FT) $display("FAIL reraise_period: got %0d want %0d", k, FT); else n_pass++;
        n_checks++; if (gap != 0) $display("FAIL reraise_gap: got %0d want 0", gap); else n_pass++;
    endtask

    task automatic test_last_pixel_drop();
        int busy_cnt;
        repeat (FT-1) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        n_checks++; if ({busy, fs, ls} !== 3'b000) $display("FAIL last_pixel_idle: got %b want 000", {busy, fs, ls}); else n_pass++;
        busy_cnt = 0;
        repeat (10) begin @(negedge clk); busy_cnt += int'(busy); end
        n_checks++; if (busy_cnt != 0) $display("FAIL stays_idle: got %0d want 0", busy_cnt); else n_pass++;
    endtask

    task automatic test_mid_reset();
        en = 1'b1;
        @(negedge clk);
        repeat (4*HT + 5) @(negedge clk);
        n_checks++; if ({hs, vs, busy} !== 3'b111) $display("FAIL pre_reset_sync: got %b want 111", {hs, vs, busy}); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (dut_vec !== 32'h0) $display("FAIL async_reset: got %h want %h", dut_vec, 32'h0); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if (dut_vec !== 32'h0) $display("FAIL reset_held: got %h want %h", dut_vec, 32'h0); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (dut_vec !== 32'h8000_0007) $display("FAIL fresh_frame: got %h want %h", dut_vec, 32'h8000_0007); else n_pass++;
    endtask

    task automatic test_lockstep();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec !== model_vec()) $display("FAIL lockstep cyc%0d: got %h want %h", i, dut_vec, model_vec());
            else n_pass++;
            en = ((i % 53) < 40) && !(i > 150 && i < 260 && m_st == 1 && m_h == HT-1 && m_v == VT-1);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_periods();
        test_sync();
        test_drain();
        test_back_to_back();
        test_last_pixel_drop();
        test_mid_reset();
        test_lockstep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
